// File: rtl/plic_define.sv
// Shared PLIC definitions: sizes, claim FSM states and the id decode helper.
package plic_define;

   localparam int PLIC_IRQ_NUM   = 32;
   localparam int PLIC_IRQ_WIDTH = 6;
   localparam int PLIC_MASK_CYC  = 3;

   // Decode space wide enough for any IRQ_NUM up to 1024 sources.
   localparam int PLIC_VEC_MAX  = 1024;
   localparam int PLIC_ID_MAX_W = 11;

   typedef enum logic {
      IDLE = 1'b0,
      MASK = 1'b1
   } claim_state_e;

   // Id j (1-based) maps to bit j-1; id 0 maps to an empty vector.
   function automatic logic [PLIC_VEC_MAX-1:0] id_to_vec(
      input logic [PLIC_ID_MAX_W-1:0] id
   );
      if (id == '0) begin
         id_to_vec = '0;
      end else begin
         id_to_vec = PLIC_VEC_MAX'(1) << (id - 1'b1);
      end
   endfunction

endpackage

// File: rtl/dffr.sv
// Register library flop: D flop with asynchronous active-high reset to zero.
module dffr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/plic_claim_ctrl.sv
// PLIC claim/complete controller: grants claims, masks eip after each claim,
// tracks in-service ids and validates completes.
module plic_claim_ctrl
   import plic_define::*;
#(
   parameter int IRQ_NUM   = PLIC_IRQ_NUM,
   parameter int IRQ_WIDTH = PLIC_IRQ_WIDTH,
   parameter int MASK_CYC  = PLIC_MASK_CYC
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 irq_i,
   input  logic [IRQ_WIDTH-1:0] idx_i,
   input  logic                 claim_i,
   input  logic                 cmpl_i,
   input  logic [IRQ_WIDTH-1:0] cmpl_id_i,
   output logic [IRQ_WIDTH-1:0] claim_id_o,
   output logic [IRQ_NUM-1:0]   clam_o,
   output logic [IRQ_NUM-1:0]   comp_o,
   output logic [IRQ_NUM-1:0]   isv_o,
   output logic                 eip_o,
   output logic                 err_o
);

   localparam int CNT_W = (MASK_CYC > 1) ? $clog2(MASK_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MASK_CYC - 1);
   localparam logic [IRQ_WIDTH-1:0] ID_LAST = IRQ_WIDTH'(IRQ_NUM);

   claim_state_e         state;
   claim_state_e         state_d;
   logic                 state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic                 claim_ok;
   logic                 cmpl_ok;
   logic [IRQ_NUM-1:0]   claim_dec;
   logic [IRQ_NUM-1:0]   cmpl_dec;
   logic [IRQ_NUM-1:0]   clam_d;
   logic [IRQ_NUM-1:0]   comp_d;
   logic [IRQ_NUM-1:0]   isv_d;
   logic                 err_d;

   assign state = claim_state_e'(state_q);

   assign eip_o      = irq_i & (idx_i != '0) & (state == IDLE);
   assign claim_id_o = eip_o ? idx_i : '0;

   assign claim_ok  = claim_i & eip_o;
   assign claim_dec = IRQ_NUM'(id_to_vec(PLIC_ID_MAX_W'(idx_i)));
   assign cmpl_dec  = IRQ_NUM'(id_to_vec(PLIC_ID_MAX_W'(cmpl_id_i)));

   assign cmpl_ok = cmpl_i
                  & (cmpl_id_i != '0)
                  & (cmpl_id_i <= ID_LAST)
                  & (|(cmpl_dec & isv_o));

   assign clam_d = claim_ok ? claim_dec : '0;
   assign comp_d = cmpl_ok ? cmpl_dec : '0;
   assign err_d  = cmpl_i & ~cmpl_ok;

   // Set after clear so a same-cycle claim of the completed id keeps it in service.
   assign isv_d = (isv_o & ~comp_d) | clam_d;

   always_comb begin
      state_d = state;
      cnt_d   = cnt_q;
      unique case (state)
         IDLE: begin
            if (claim_ok) begin
               state_d = MASK;
               cnt_d   = CNT_LOAD;
            end
         end
         MASK: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   dffr #(.W(1)) u_state (
      .clk (clk_i),
      .rst (rst_i),
      .d   (state_d),
      .q   (state_q)
   );

   dffr #(.W(CNT_W)) u_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .d   (cnt_d),
      .q   (cnt_q)
   );

   dffr #(.W(IRQ_NUM)) u_clam (
      .clk (clk_i),
      .rst (rst_i),
      .d   (clam_d),
      .q   (clam_o)
   );

   dffr #(.W(IRQ_NUM)) u_comp (
      .clk (clk_i),
      .rst (rst_i),
      .d   (comp_d),
      .q   (comp_o)
   );

   dffr #(.W(IRQ_NUM)) u_isv (
      .clk (clk_i),
      .rst (rst_i),
      .d   (isv_d),
      .q   (isv_o)
   );

   dffr #(.W(1)) u_err (
      .clk (clk_i),
      .rst (rst_i),
      .d   (err_d),
      .q   (err_o)
   );

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: vector table with a next-cycle scoreboard,
// followed by a hand-written reset-during-mask sequence.
module tb_plic_claim_ctrl;

   localparam int N = 32;
   localparam int W = 6;

   logic         clk;
   logic         rst;
   logic         irq;
   logic [W-1:0] idx;
   logic         claim;
   logic         cmpl;
   logic [W-1:0] cmpl_id;
   logic [W-1:0] claim_id;
   logic [N-1:0] clam;
   logic [N-1:0] comp;
   logic [N-1:0] isv;
   logic         eip;
   logic         err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          irq;
      int          idx;
      bit          claim;
      bit          cmpl;
      int          cid;
      int          e_cid;
      bit          e_eip;
      logic [31:0] e_clam;
      logic [31:0] e_comp;
      logic [31:0] e_isv;
      bit          e_err;
   } vec_t;

   typedef struct {
      logic [31:0] clam;
      logic [31:0] comp;
      logic [31:0] isv;
      bit          err;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   plic_claim_ctrl #(
      .IRQ_NUM   (N),
      .IRQ_WIDTH (W),
      .MASK_CYC  (3)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .irq_i      (irq),
      .idx_i      (idx),
      .claim_i    (claim),
      .cmpl_i     (cmpl),
      .cmpl_id_i  (cmpl_id),
      .claim_id_o (claim_id),
      .clam_o     (clam),
      .comp_o     (comp),
      .isv_o      (isv),
      .eip_o      (eip),
      .err_o      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void add(
      input bit irq_v, input int idx_v, input bit claim_v,
      input bit cmpl_v, input int cid_v,
      input int ecid, input bit eeip,
      input logic [31:0] eclam, input logic [31:0] ecomp,
      input logic [31:0] eisv, input bit eerr);
      vec_t v;
      v.irq    = irq_v;
      v.idx    = idx_v;
      v.claim  = claim_v;
      v.cmpl   = cmpl_v;
      v.cid    = cid_v;
      v.e_cid  = ecid;
      v.e_eip  = eeip;
      v.e_clam = eclam;
      v.e_comp = ecomp;
      v.e_isv  = eisv;
      v.e_err  = eerr;
      tbl.push_back(v);
   endfunction

   initial begin
      exp_t e;
      rst     = 1'b1;
      irq     = 1'b0;
      idx     = '0;
      claim   = 1'b0;
      cmpl    = 1'b0;
      cmpl_id = '0;

      //  irq idx clm cmp cid | cid eip  clam          comp          isv           err
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(0, 5,  1, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(1, 5,  0, 0, 0,    5, 1, 32'h0,        32'h0,        32'h0,        0);
      add(1, 5,  1, 0, 0,    5, 1, 32'h10,       32'h0,        32'h10,       0);
      add(1, 5,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h10,       0);
      add(1, 5,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h10,       0);
      add(1, 5,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h10,       0);
      add(1, 5,  0, 0, 0,    5, 1, 32'h0,        32'h0,        32'h10,       0);
      add(0, 0,  0, 1, 5,    0, 0, 32'h0,        32'h10,       32'h0,        0);
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(1, 3,  1, 0, 0,    3, 1, 32'h4,        32'h0,        32'h4,        0);
      add(0, 0,  0, 1, 0,    0, 0, 32'h0,        32'h0,        32'h4,        1);
      add(0, 0,  0, 1, 33,   0, 0, 32'h0,        32'h0,        32'h4,        1);
      add(0, 0,  0, 1, 7,    0, 0, 32'h0,        32'h0,        32'h4,        1);
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h4,        0);
      add(1, 3,  1, 1, 3,    3, 1, 32'h4,        32'h4,        32'h4,        0);
      add(1, 3,  0, 1, 3,    0, 0, 32'h0,        32'h4,        32'h0,        0);
      add(1, 3,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(1, 3,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(1, 3,  1, 0, 0,    3, 1, 32'h4,        32'h0,        32'h4,        0);
      add(1, 8,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h4,        0);
      add(1, 8,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h4,        0);
      add(1, 8,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h4,        0);
      add(1, 8,  1, 0, 0,    8, 1, 32'h80,       32'h0,        32'h84,       0);
      add(0, 0,  0, 1, 8,    0, 0, 32'h0,        32'h80,       32'h4,        0);
      add(0, 0,  0, 1, 3,    0, 0, 32'h0,        32'h4,        32'h0,        0);
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(1, 32, 1, 0, 0,    32, 1, 32'h80000000, 32'h0,       32'h80000000, 0);
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h80000000, 0);
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h80000000, 0);
      add(0, 0,  0, 0, 0,    0, 0, 32'h0,        32'h0,        32'h80000000, 0);
      add(0, 0,  0, 1, 32,   0, 0, 32'h0,        32'h80000000, 32'h0,        0);
      add(1, 0,  1, 0, 0,    0, 0, 32'h0,        32'h0,        32'h0,        0);
      add(0, 0,  0, 1, 32,   0, 0, 32'h0,        32'h0,        32'h0,        1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst clam", 32'(clam), 32'h0);
      chk("rst comp", 32'(comp), 32'h0);
      chk("rst isv",  32'(isv),  32'h0);
      chk("rst err",  32'(err),  32'h0);
      chk("rst eip",  32'(eip),  32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         irq     = tbl[i].irq;
         idx     = W'(tbl[i].idx);
         claim   = tbl[i].claim;
         cmpl    = tbl[i].cmpl;
         cmpl_id = W'(tbl[i].cid);
         #1;
         chk($sformatf("r%0d claim_id", i), 32'(claim_id), 32'(tbl[i].e_cid));
         chk($sformatf("r%0d eip", i), 32'(eip), 32'(tbl[i].e_eip));
         e.clam = tbl[i].e_clam;
         e.comp = tbl[i].e_comp;
         e.isv  = tbl[i].e_isv;
         e.err  = tbl[i].e_err;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            chk($sformatf("r%0d sb empty", i), 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk($sformatf("r%0d clam", i), 32'(clam), e.clam);
            chk($sformatf("r%0d comp", i), 32'(comp), e.comp);
            chk($sformatf("r%0d isv", i),  32'(isv),  e.isv);
            chk($sformatf("r%0d err", i),  32'(err),  32'(e.err));
         end
      end

      // Claim id 9, then reset during the second mask cycle.
      @(negedge clk);
      irq     = 1'b1;
      idx     = W'(9);
      claim   = 1'b1;
      cmpl    = 1'b0;
      cmpl_id = '0;
      #1;
      chk("r9 eip", 32'(eip), 32'd1);
      chk("r9 claim_id", 32'(claim_id), 32'd9);
      @(posedge clk);
      #1;
      chk("r9 clam", 32'(clam), 32'h100);
      chk("r9 isv", 32'(isv), 32'h100);
      chk("r9 mask eip", 32'(eip), 32'd0);
      @(negedge clk);
      claim = 1'b0;
      @(posedge clk);
      #1;
      chk("r9 mask2 eip", 32'(eip), 32'd0);
      #2;
      irq = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst clam", 32'(clam), 32'h0);
      chk("arst comp", 32'(comp), 32'h0);
      chk("arst isv", 32'(isv), 32'h0);
      chk("arst err", 32'(err), 32'h0);
      chk("arst eip", 32'(eip), 32'h0);
      chk("arst claim_id", 32'(claim_id), 32'h0);
      irq = 1'b1;
      idx = W'(9);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel eip", 32'(eip), 32'd1);
      @(posedge clk);
      #1;
      chk("post eip", 32'(eip), 32'd1);
      chk("post claim_id", 32'(claim_id), 32'd9);
      chk("post isv", 32'(isv), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/plic_claim_ctrl.md
PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

Interface
REQ-001 The block SHALL have parameter IRQ_NUM, default 32, meaning the number of interrupt sources (ids 1..IRQ_NUM; id 0 means "none").
REQ-002 The block SHALL have parameter IRQ_WIDTH, default 6, meaning the id width; it SHALL satisfy 2**IRQ_WIDTH > IRQ_NUM.
REQ-003 The block SHALL have parameter MASK_CYC, default 3, meaning the number of cycles eip_o stays masked after a claim.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port irq_i, input, 1 bit: registered "best priority > threshold" flag from plic_core.
REQ-007 The block SHALL have port idx_i, input, IRQ_WIDTH bits: registered winning id from plic_core.
REQ-008 The block SHALL have port claim_i, input, 1 bit: one-cycle strobe for a read of the claim register.
REQ-009 The block SHALL have port cmpl_i, input, 1 bit: one-cycle strobe for a write of the complete register.
REQ-010 The block SHALL have port cmpl_id_i, input, IRQ_WIDTH bits: the id written with cmpl_i.
REQ-011 The block SHALL have port claim_id_o, output, IRQ_WIDTH bits: the read data for the claim register.
REQ-012 The block SHALL have port clam_o, output, IRQ_NUM bits: one-hot claim pulse to the gateways; bit j corresponds to id j+1.
REQ-013 The block SHALL have port comp_o, output, IRQ_NUM bits: one-hot complete pulse to the gateways; bit j corresponds to id j+1.
REQ-014 The block SHALL have port isv_o, output, IRQ_NUM bits: the in-service vector.
REQ-015 The block SHALL have port eip_o, output, 1 bit: external interrupt pending to the hart.
REQ-016 The block SHALL have port err_o, output, 1 bit: one-cycle pulse flagging an illegal complete.

Function
REQ-017 The block SHALL drive eip_o combinationally as irq_i AND (idx_i != 0) AND (state == IDLE).
REQ-018 The block SHALL drive claim_id_o combinationally as idx_i when eip_o = 1, and as 0 otherwise.
REQ-019 A claim SHALL be accepted when claim_i = 1 and eip_o = 1 in the same cycle; in the next cycle clam_o SHALL be one-hot at bit idx_i-1 for exactly 1 cycle, and isv_o bit idx_i-1 SHALL be set.
REQ-020 A claim_i with eip_o = 0 SHALL return 0, produce no clam_o pulse and leave the state unchanged.
REQ-021 The FSM SHALL have two states, IDLE and MASK; an accepted claim SHALL move IDLE to MASK and load the mask counter with MASK_CYC-1.
REQ-022 In MASK the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE in the cycle after the counter reaches 0, so eip_o is low for exactly MASK_CYC cycles after the claim cycle.
REQ-023 A complete SHALL be legal when cmpl_i = 1, 1 <= cmpl_id_i <= IRQ_NUM and isv_o bit cmpl_id_i-1 = 1; in the next cycle comp_o SHALL pulse that bit for 1 cycle and the isv bit SHALL clear.
REQ-024 An illegal complete (id 0, id > IRQ_NUM, or id not in service) SHALL change no state, produce no comp_o pulse, and pulse err_o for 1 cycle in the next cycle.
REQ-025 A claim and a complete in the same cycle SHALL both be processed; if they target the same id, the isv bit SHALL end set (claim wins) and comp_o SHALL still pulse.
REQ-026 The complete path SHALL be independent of FSM state; a complete during MASK SHALL be honoured.
REQ-027 Multiple ids SHALL be allowed in service concurrently (nested claims); isv_o SHALL never clear a bit except on a legal complete or reset.
REQ-028 clam_o and comp_o SHALL be registered and SHALL never carry more than one set bit each.

Reset
REQ-029 On rst_i assertion the block SHALL asynchronously force state = IDLE, mask counter = 0, clam_o = 0, comp_o = 0, isv_o = 0 and err_o = 0.
REQ-030 A reset asserted mid-MASK SHALL abort the mask; after release eip_o SHALL follow irq_i immediately.
REQ-031 Reset release SHALL be synchronous to clk_i at the register level; there SHALL be no state change in the release cycle other than normal operation.

Structure
REQ-032 The FSM state enum, MASK_CYC default and id-to-vector decode function SHALL live in the shared plic_define package alongside PLIC_IRQ_NUM and PLIC_IRQ_WIDTH.
REQ-033 The registers SHALL use the codebase's register library flops (asynchronous active-high reset variant).
REQ-034 The block SHALL contain no sub-module other than those flops; the id-to-one-hot decode SHALL be a package function.

Verification
REQ-035 Bench scenario: irq_i=1, idx_i=5, claim_i pulse -> claim_id_o=5 in that cycle, clam_o=32'h10 next cycle, isv_o bit4=1, eip_o low 3 cycles.
REQ-036 Bench scenario: complete with cmpl_id_i=5 while bit4 is in service -> comp_o=32'h10 for 1 cycle, isv_o=0, err_o=0.
REQ-037 Bench scenario: complete with cmpl_id_i=0, then 33, then 7 (not in service) -> err_o pulses each time, no comp_o, isv_o unchanged.
REQ-038 Bench scenario: claim id 3 together with complete id 3 (3 in service) -> comp_o bit2 pulses, clam_o bit2 pulses, isv_o bit2 remains 1.
REQ-039 Bench scenario: claim id 9, assert rst_i on the 2nd MASK cycle -> all outputs 0 asynchronously; after release with irq_i=1, idx_i=9, eip_o=1 the next cycle.
REQ-040 Bench scenario: claim_i with irq_i=0 -> claim_id_o=0, no clam_o pulse, FSM stays IDLE.
